finv_arbiter: RTL and testbench

Round-robin arbiter that shares one fully pipelined `finv` reciprocal unit between `NREQ` requesters. It issues at most one operand per cycle into the unit and tracks each in-flight operation with a tag pipeline matched to the unit's fixed latency. Each result is steered into a per-requester result FIFO. Issue is credit-gated: `finv` cannot stall, so an operand is never launched unless its destination FIFO is guaranteed a free slot.

---
 rtl/finv_pkg.sv | 39 +++
 rtl/finv_arbiter_if.sv | 19 +
 rtl/finv_arb_fifo.sv | 50 +++++
 rtl/finv_arbiter.sv | 118 +++++++++++
 tb/tb_finv_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/finv_pkg.sv
// Shared types and helpers for the finv round-robin arbiter.
// Sizes tags for up to eight requesters.
package finv_pkg;

    localparam int FINV_LAT     = 3;
    localparam int FINV_DEPTH   = 4;
    localparam int FINV_MAX_REQ = 8;
    localparam int PORT_W       = 3;

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] port;
        logic              special;
    } finv_tag_t;

    typedef struct packed {
        logic              found;
        logic [PORT_W-1:0] idx;
    } rr_pick_t;

    // First eligible port at or after rr, wrapping modulo nreq.
    function automatic rr_pick_t rr_pick(input logic [FINV_MAX_REQ-1:0] elig,
                                         input logic [PORT_W-1:0]       rr,
                                         input int                      nreq);
        rr_pick_t r;
        int       p;
        r = '0;
        for (int k = 0; k < FINV_MAX_REQ; k++) begin
            p = int'(rr) + k;
            if (p >= nreq) p = p - nreq;
            if (k < nreq && !r.found && elig[p]) begin
                r.found = 1'b1;
                r.idx   = PORT_W'(p);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/finv_arbiter_if.sv
// Requester, result and finv-unit signals of the arbiter.
// The slave modport is the arbiter side; master is the environment side.
interface finv_arbiter_if #(parameter int NREQ = 4) ();

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0][31:0] req_x;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       res_valid;
    logic [NREQ-1:0][31:0] res_y;
    logic [NREQ-1:0]       res_ready;
    logic [31:0]           fx;
    logic [31:0]           fy;

    modport slave  (input  req_valid, req_x, res_ready, fy,
                    output req_ready, res_valid, res_y, fx);
    modport master (output req_valid, req_x, res_ready, fy,
                    input  req_ready, res_valid, res_y, fx);

endinterface

// File: rtl/finv_arb_fifo.sv
// Per-requester result FIFO, 32 bits wide; head reads as zero when empty.
// A write and a pop in the same cycle are both honoured, even when full.
module finv_arb_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_i,
    input  logic [31:0] wr_data_i,
    input  logic        pop_i,
    output logic        empty_o,
    output logic [31:0] head_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = empty_o ? 32'd0 : mem_q[rd_ptr_q];

    // NOTE: storage has no reset; occupancy is tracked by count_q, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            assert (!(wr_en_i && count_q == CW'(DEPTH) && !do_pop));
            if (wr_en_i) wr_ptr_q <= bump(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= bump(rd_ptr_q);
            if (wr_en_i && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !wr_en_i) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/finv_arbiter.sv
// Round-robin, credit-gated arbiter sharing one pipelined finv unit among NREQ ports.
// Optional feature: define FINV_ARB_SPECIAL_EN to return +/-inf for zero-exponent operands.
module finv_arbiter
    import finv_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LAT   = FINV_LAT,
    parameter int DEPTH = FINV_DEPTH
) (
    input logic           clk,
    input logic           rst,
    finv_arbiter_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [NREQ-1:0]         elig, grant, pop, fifo_empty, wr_en;
    logic [FINV_MAX_REQ-1:0] elig_ext;
    logic [CW-1:0]           credit_q [NREQ];
    logic [CW-1:0]           credit_d [NREQ];
    logic [PORT_W-1:0]       rr_q, rr_d;
    finv_tag_t               tag_q [LAT];
    finv_tag_t               issue_tag, last_tag;
    rr_pick_t                pick;
    logic                    issue_special;
    logic [31:0]             capture_data;
    logic [NREQ-1:0][31:0]   head;

    // NOTE: combinational blocks use blocking '=' with a default first, so no latch is inferred.
    always_comb begin
        elig     = '0;
        elig_ext = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = bus.req_valid[i] && (credit_q[i] != '0);
        end
        elig_ext[NREQ-1:0] = elig;
        pick = rr_pick(elig_ext, rr_q, NREQ);
    end

    always_comb begin
        grant  = '0;
        bus.fx = 32'd0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = pick.found && (pick.idx == PORT_W'(i));
            if (grant[i]) bus.fx = bus.req_x[i];
        end
    end

`ifdef FINV_ARB_SPECIAL_EN
    assign issue_special = pick.found && (bus.fx[30:23] == 8'd0);
`else
    assign issue_special = 1'b0;
`endif

    assign issue_tag = '{valid: pick.found, port: pick.idx, special: issue_special};

    always_comb begin
        rr_d = rr_q;
        if (pick.found) rr_d = (pick.idx == PORT_W'(NREQ - 1)) ? '0 : pick.idx + 1'b1;
    end

    // Credits count free FIFO slots not yet reserved by in-flight operations.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            pop[i]      = !fifo_empty[i] && bus.res_ready[i];
            credit_d[i] = credit_q[i];
            if (grant[i] && !pop[i])      credit_d[i] = credit_q[i] - 1'b1;
            else if (pop[i] && !grant[i]) credit_d[i] = credit_q[i] + 1'b1;
        end
    end

    assign last_tag = tag_q[LAT-1];

`ifdef FINV_ARB_SPECIAL_EN
    assign capture_data = last_tag.special ? {bus.fy[31], 8'hFF, 23'd0} : bus.fy;
`else
    assign capture_data = bus.fy;
`endif

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            wr_en[i] = last_tag.valid && (last_tag.port == PORT_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
            for (int i = 0; i < NREQ; i++) credit_q[i] <= CW'(DEPTH);
            for (int s = 0; s < LAT; s++)  tag_q[s]    <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                assert (!(pop[i] && !grant[i] && credit_q[i] == CW'(DEPTH)));
            end
            rr_q     <= rr_d;
            credit_q <= credit_d;
            tag_q[0] <= issue_tag;
            for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_port
        finv_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (wr_en[i]),
            .wr_data_i (capture_data),
            .pop_i     (bus.res_ready[i]),
            .empty_o   (fifo_empty[i]),
            .head_o    (head[i])
        );
    end

    assign bus.req_ready = grant;
    assign bus.res_valid = ~fifo_empty;
    assign bus.res_y     = head;

endmodule

// File: tb/tb_finv_arbiter.sv
// Randomized scoreboard bench for finv_arbiter with a behavioural finv unit model.
// Expected grants come from queue occupancy; a negedge monitor checks every result port.
module tb_finv_arbiter;
    import finv_pkg::*;

    localparam int NREQ  = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    finv_arbiter_if #(.NREQ(NREQ)) bus ();

    finv_arbiter #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Crude reciprocal: exact for powers of two, sign preserved.
    function automatic logic [31:0] finv_model(input logic [31:0] x);
        logic [7:0] e;
        e = x[30:23];
        if (x[22:0] == 23'd0) return {x[31], 8'(254 - int'(e)), 23'd0};
        return {x[31], 8'(253 - int'(e)), ~x[22:0]};
    endfunction

    function automatic logic [31:0] exp_result(input logic [31:0] x);
`ifdef FINV_ARB_SPECIAL_EN
        if (x[30:23] == 8'd0) return {x[31], 8'hFF, 23'd0};
`endif
        return finv_model(x);
    endfunction

    logic [31:0] fpipe [LAT];
    always @(posedge clk) begin
        fpipe[0] <= bus.fx;
        for (int s = 1; s < LAT; s++) fpipe[s] <= fpipe[s-1];
    end
    assign bus.fy = finv_model(fpipe[LAT-1]);

    typedef struct {
        logic [31:0] data;
        int          ready_cyc;
    } exp_t;

    exp_t            exp_q [NREQ][$];
    int              rr_m = 0;
    int              cyc = 0;
    int              n_cmp = 0;
    int              n_err = 0;
    logic [NREQ-1:0] pend = '0;
    logic [31:0]     px [NREQ];
    int              start_pct [NREQ];
    int              rdy_pct [NREQ];
    int              withdraw_pct = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(7) == 0) r[30:23] = 8'd0;
        if ($urandom_range(5) == 0) r[22:0] = 23'd0;
        return r;
    endfunction

    function automatic int outstanding();
        int n;
        n = 0;
        for (int i = 0; i < NREQ; i++) n += exp_q[i].size();
        return n;
    endfunction

    // One clock cycle: drive requesters, predict the grant, check it, record the expected result.
    task automatic step(input bit do_rst = 1'b0);
        int              g;
        int              p;
        logic [NREQ-1:0] exp_ready;
        exp_t            e;
        @(posedge clk);
        #1;
        rst = do_rst;
        for (int i = 0; i < NREQ; i++) begin
            if (do_rst) pend[i] = 1'b0;
            else if (pend[i] && $urandom_range(99) < withdraw_pct) pend[i] = 1'b0;
            else if (!pend[i] && $urandom_range(99) < start_pct[i]) begin
                pend[i] = 1'b1;
                px[i]   = rand_operand();
            end
            bus.req_valid[i] = pend[i];
            bus.req_x[i]     = pend[i] ? px[i] : $urandom();
            bus.res_ready[i] = !do_rst && ($urandom_range(99) < rdy_pct[i]);
        end
        #1;
        if (do_rst) begin
            for (int i = 0; i < NREQ; i++) exp_q[i].delete();
            rr_m = 0;
        end
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            p = (rr_m + k) % NREQ;
            if (g < 0 && pend[p] && exp_q[p].size() < DEPTH) g = p;
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("fx", bus.fx, (g >= 0) ? px[g] : 32'd0);
        if (g >= 0) begin
            e.data      = exp_result(px[g]);
            e.ready_cyc = cyc + LAT + 1;
            exp_q[g].push_back(e);
            pend[g] = 1'b0;
            rr_m    = (g + 1) % NREQ;
        end
    endtask

    task automatic set_all(input int s_pct, input int r_pct);
        for (int i = 0; i < NREQ; i++) begin
            start_pct[i] = s_pct;
            rdy_pct[i]   = r_pct;
        end
    endtask

    task automatic drain();
        set_all(0, 100);
        withdraw_pct = 0;
        for (int k = 0; k < 80 && (pend != '0 || outstanding() > 0); k++) step();
        check("drain_outstanding", 32'(outstanding()), 32'd0);
    endtask

    always @(negedge clk) begin : monitor
        bit ev;
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                ev = exp_q[i].size() > 0 && exp_q[i][0].ready_cyc <= cyc;
                check($sformatf("res_valid[%0d]", i), 32'(bus.res_valid[i]), 32'(ev));
                if (ev) begin
                    check($sformatf("res_y[%0d]", i), bus.res_y[i], exp_q[i][0].data);
                    if (bus.res_ready[i]) void'(exp_q[i].pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.res_ready = '0;
        set_all(0, 0);

        step(1'b1);
        step(1'b1);
        step();
        for (int i = 0; i < NREQ; i++) begin
            check($sformatf("reset_res_y[%0d]", i), bus.res_y[i], 32'd0);
        end
        check("reset_res_valid", 32'(bus.res_valid), 32'd0);

        // Single operation on port 0
        set_all(0, 100);
        pend[0] = 1'b1;
        px[0]   = 32'h4000_0000;
        for (int k = 0; k < 8; k++) step();

        // All ports continuously valid
        set_all(100, 100);
        for (int k = 0; k < 40; k++) step();
        drain();

        // Backpressure on port 2, then release it for a single cycle
        set_all(50, 100);
        start_pct[2] = 100;
        rdy_pct[2]   = 0;
        for (int k = 0; k < 20; k++) step();
        rdy_pct[2] = 100;
        step();
        rdy_pct[2] = 0;
        for (int k = 0; k < 8; k++) step();
        drain();

        // Port 1 full, then popped every cycle while streaming
        set_all(0, 100);
        start_pct[1] = 100;
        rdy_pct[1]   = 0;
        for (int k = 0; k < 10; k++) step();
        rdy_pct[1] = 100;
        for (int k = 0; k < 12; k++) step();
        drain();

        // Randomized traffic
        withdraw_pct = 5;
        for (int blk = 0; blk < 15; blk++) begin
            for (int i = 0; i < NREQ; i++) begin
                start_pct[i] = $urandom_range(90, 20);
                rdy_pct[i]   = ($urandom_range(3) == 0) ? 0 : $urandom_range(100, 30);
            end
            for (int k = 0; k < 100; k++) step();
        end
        drain();

        // Reset two cycles after an issue; stale finv output must be dropped
        set_all(0, 100);
        pend[1] = 1'b1;
        px[1]   = 32'h3F80_0000;
        step();
        step();
        step(1'b1);
        set_all(0, 0);
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b1;
            px[i]   = rand_operand();
        end
        step();
        start_pct[3] = 100;
        for (int k = 0; k < 10; k++) step();
        drain();

        // Zero-exponent operand
        set_all(0, 100);
        pend[1] = 1'b1;
        px[1]   = 32'h8000_0000;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
